rob_ar_arbiter: RTL and testbench
=================================

ROB_AR_ARBITER -- requirements
Module: rob_ar_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, read-data width, equal to the downstream reorder buffer's.
REQ-002 SHALL have parameter MAX_OUTST, default 16, outstanding-read limit, equal to the reorder-buffer depth.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rN_arid_i  input  4  requester N (N = 0, 1) AR id.
REQ-006 rN_arvalid_i / rN_arready_o  input / output  1  requester N AR handshake.
REQ-007 rN_rdata_o / rN_rid_o  output  DATA_WIDTH / 4  requester N R payload.
REQ-008 rN_rvalid_o / rN_rready_i  output / input  1  requester N R handshake.
REQ-009 rob_arid_o / rob_arvalid_o / rob_arready_i  out / out / in  4/1/1  AR port to the reorder buffer.
REQ-010 rob_rdata_i / rob_rid_i / rob_rvalid_i / rob_rready_o  in/in/in/out  DATA_WIDTH/4/1/1  in-order R port from the reorder buffer.
REQ-011 outst_o  output  5  current outstanding count.
REQ-012 err_o  output  1  sticky protocol-error flag.

Function
REQ-013 Grant (gnt, 1 bit): if a lock is held, gnt = locked requester; else the requester that rr_ptr points to if its arvalid is high, otherwise the other one.
REQ-014 can_issue = (outst < MAX_OUTST); rob_arvalid_o = rgnt_arvalid_i AND can_issue; rob_arid_o = rgnt_arid_i; all combinational, zero latency.
REQ-015 rgnt_arready_o = rob_arready_i AND can_issue; the non-granted arready SHALL be 0.
REQ-016 AR handshake = rob_arvalid_o AND rob_arready_i.
REQ-017 Lock: set when rob_arvalid_o = 1 without a handshake; held until that requester's handshake, keeping gnt and rob_arid_o stable.
REQ-018 On each AR handshake, rr_ptr SHALL become NOT gnt.
REQ-019 Route FIFO: MAX_OUTST x 1 bit; pushes gnt on AR handshake; pops on R handshake; 4-bit pointers wrap 15 -> 0.
REQ-020 R routing: rN_rvalid_o = rob_rvalid_i AND (outst != 0) AND (head == N); rob_rready_o = rhead_rready_i AND (outst != 0).
REQ-021 rob_rdata_i and rob_rid_i SHALL fan out unregistered to both requesters.
REQ-022 R handshake = rob_rvalid_i AND rob_rready_o.
REQ-023 outst: +1 on AR handshake only; -1 on R handshake only; unchanged when both occur in one cycle; range 0..MAX_OUTST.
REQ-024 At outst = MAX_OUTST, no AR issues; a same-cycle R handshake frees a credit from the next cycle, not the same cycle.
REQ-025 err_o SHALL set when rob_rvalid_i = 1 while outst = 0; the beat SHALL be dropped (rob_rready_o = 0), and err_o stays set until reset.

Reset
REQ-026 While rst_n = 0: outst = 0, rr_ptr = 0, lock clear, FIFO pointers 0, err_o = 0; hence all rvalid/arvalid/arready outputs are 0.
REQ-027 A reset mid-transaction SHALL discard all outstanding routing state; beats arriving after reset SHALL be handled per REQ-025.

Verification
REQ-028 r0 and r1 arvalid both high, rob_arready_i = 1, 4 cycles -> grants r0, r1, r0, r1; outst = 4.
REQ-029 r1_arvalid_i = 1 with id 0x5, rob_arready_i = 0 for 3 cycles, r0 raised in cycle 2 -> rob_arid_o holds 0x5 with grant r1 until the handshake.
REQ-030 16 AR issued, none returned -> arvalid to rob = 0 on the 17th request; one R beat with a same-cycle pending AR -> AR issues the next cycle; outst returns to 16.
REQ-031 Issue order r0, r1, r1, then 3 R beats with rid 2, 7, 9 -> beats delivered to r0, r1, r1 in order; r1_rready_i = 0 stalls rob_rready_o.
REQ-032 rob_rvalid_i = 1 with outst = 0 -> err_o = 1 next cycle, no requester rvalid; rst_n pulse low -> err_o = 0 and outst = 0.

Source files
------------

// File: rtl/rob_ar_arbiter.sv
// rob_ar_arbiter: round-robin AR arbiter for two requesters in front of a reorder buffer,
// routing the in-order R stream back to the issuing requester through a 1-bit route FIFO.
module rob_ar_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_OUTST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            r0_arid_i,
    input  logic                  r0_arvalid_i,
    output logic                  r0_arready_o,
    output logic [DATA_WIDTH-1:0] r0_rdata_o,
    output logic [3:0]            r0_rid_o,
    output logic                  r0_rvalid_o,
    input  logic                  r0_rready_i,
    input  logic [3:0]            r1_arid_i,
    input  logic                  r1_arvalid_i,
    output logic                  r1_arready_o,
    output logic [DATA_WIDTH-1:0] r1_rdata_o,
    output logic [3:0]            r1_rid_o,
    output logic                  r1_rvalid_o,
    input  logic                  r1_rready_i,
    output logic [3:0]            rob_arid_o,
    output logic                  rob_arvalid_o,
    input  logic                  rob_arready_i,
    input  logic [DATA_WIDTH-1:0] rob_rdata_i,
    input  logic [3:0]            rob_rid_i,
    input  logic                  rob_rvalid_i,
    output logic                  rob_rready_o,
    output logic [4:0]            outst_o,
    output logic                  err_o
);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [4:0]           r_outst;
    logic                 r_rr_ptr;
    logic                 r_lock;
    logic                 r_lock_gnt;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [MAX_OUTST-1:0] r_fifo;
    logic                 r_err;

    logic w_gnt;
    logic w_can;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_head;
    logic w_has;

    always_comb begin
        w_gnt = r_lock ? r_lock_gnt
              : r_rr_ptr ? ~r1_arvalid_i
              : r0_arvalid_i ? 1'b0 : 1'b1;
        w_gnt = r_lock ? r_lock_gnt : (r_rr_ptr ? (r1_arvalid_i ? 1'b1 : 1'b0) : (r0_arvalid_i ? 1'b0 : 1'b1));
    end

    // Reset gating keeps every handshake output low while rst_n is held.
    assign w_can         = rst_n & (r_outst < 5'(MAX_OUTST));
    assign rob_arvalid_o = (w_gnt ? r1_arvalid_i : r0_arvalid_i) & w_can;
    assign rob_arid_o    = w_gnt ? r1_arid_i : r0_arid_i;
    assign r0_arready_o  = ~w_gnt & rob_arready_i & w_can;
    assign r1_arready_o  = w_gnt & rob_arready_i & w_can;
    assign w_ar_hs       = rob_arvalid_o & rob_arready_i;

    assign w_has        = r_outst != 5'd0;
    assign w_head       = r_fifo[r_rptr];
    assign r0_rvalid_o  = rob_rvalid_i & w_has & ~w_head;
    assign r1_rvalid_o  = rob_rvalid_i & w_has & w_head;
    assign rob_rready_o = (w_head ? r1_rready_i : r0_rready_i) & w_has;
    assign w_r_hs       = rob_rvalid_i & rob_rready_o;

    assign r0_rdata_o = rob_rdata_i;
    assign r1_rdata_o = rob_rdata_i;
    assign r0_rid_o   = rob_rid_i;
    assign r1_rid_o   = rob_rid_i;
    assign outst_o    = r_outst;
    assign err_o      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outst    <= '0;
            r_rr_ptr   <= 1'b0;
            r_lock     <= 1'b0;
            r_lock_gnt <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fifo     <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_lock         <= 1'b0;
                r_rr_ptr       <= ~w_gnt;
                r_fifo[r_wptr] <= w_gnt;
                r_wptr         <= (r_wptr == PW'(MAX_OUTST - 1)) ? '0 : r_wptr + 1'b1;
            end else if (rob_arvalid_o) begin
                r_lock     <= 1'b1;
                r_lock_gnt <= w_gnt;
            end
            if (w_r_hs)
                r_rptr <= (r_rptr == PW'(MAX_OUTST - 1)) ? '0 : r_rptr + 1'b1;
            if (w_ar_hs && !w_r_hs)
                r_outst <= r_outst + 5'd1;
            else if (w_r_hs && !w_ar_hs)
                r_outst <= r_outst - 5'd1;
            if (rob_rvalid_i && !w_has)
                r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rob_ar_arbiter.sv
// tb_rob_ar_arbiter: directed scenario tasks with hand-computed expectations for rob_ar_arbiter.
module tb_rob_ar_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] r0_arid_i, r1_arid_i, rob_rid_i;
    logic       r0_arvalid_i, r1_arvalid_i, r0_rready_i, r1_rready_i;
    logic       rob_arready_i, rob_rvalid_i;
    logic [7:0] rob_rdata_i;
    logic       r0_arready_o, r1_arready_o, r0_rvalid_o, r1_rvalid_o;
    logic [7:0] r0_rdata_o, r1_rdata_o;
    logic [3:0] r0_rid_o, r1_rid_o, rob_arid_o;
    logic       rob_arvalid_o, rob_rready_o, err_o;
    logic [4:0] outst_o;
    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    rob_ar_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_arid_i(r0_arid_i), .r0_arvalid_i(r0_arvalid_i), .r0_arready_o(r0_arready_o),
        .r0_rdata_o(r0_rdata_o), .r0_rid_o(r0_rid_o), .r0_rvalid_o(r0_rvalid_o), .r0_rready_i(r0_rready_i),
        .r1_arid_i(r1_arid_i), .r1_arvalid_i(r1_arvalid_i), .r1_arready_o(r1_arready_o),
        .r1_rdata_o(r1_rdata_o), .r1_rid_o(r1_rid_o), .r1_rvalid_o(r1_rvalid_o), .r1_rready_i(r1_rready_i),
        .rob_arid_o(rob_arid_o), .rob_arvalid_o(rob_arvalid_o), .rob_arready_i(rob_arready_i),
        .rob_rdata_i(rob_rdata_i), .rob_rid_i(rob_rid_i), .rob_rvalid_i(rob_rvalid_i), .rob_rready_o(rob_rready_o),
        .outst_o(outst_o), .err_o(err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r0_arvalid_i = 0; r1_arvalid_i = 0; rob_arready_i = 0;
        rob_rvalid_i = 0; r0_rready_i = 0; r1_rready_i = 0;
    endtask

    task automatic test_reset();
        idle();
        r0_arid_i = 4'h0; r1_arid_i = 4'h0; rob_rid_i = 4'h0; rob_rdata_i = 8'h00;
        rst_n = 0;
        #2;
        r0_arvalid_i = 1; rob_arready_i = 1;
        step(); step();
        nchk++; if (outst_o !== 5'd0) begin nfail++; $display("FAIL reset_outst got=%0d exp=0", outst_o); end
        nchk++; if (err_o !== 1'b0) begin nfail++; $display("FAIL reset_err got=%b exp=0", err_o); end
        nchk++; if (rob_arvalid_o !== 1'b0) begin nfail++; $display("FAIL reset_arvalid got=%b exp=0", rob_arvalid_o); end
        nchk++; if (r0_arready_o !== 1'b0) begin nfail++; $display("FAIL reset_arready got=%b exp=0", r0_arready_o); end
        idle();
        rst_n = 1;
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_id [4] = '{4'h1, 4'h2, 4'h1, 4'h2};
        r0_arid_i = 4'h1; r1_arid_i = 4'h2;
        r0_arvalid_i = 1; r1_arvalid_i = 1; rob_arready_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            nchk++; if (rob_arid_o !== exp_id[i]) begin nfail++; $display("FAIL rr_arid[%0d] got=%h exp=%h", i, rob_arid_o, exp_id[i]); end
            nchk++; if (r0_arready_o !== (i % 2 == 0)) begin nfail++; $display("FAIL rr_r0_arready[%0d] got=%b exp=%b", i, r0_arready_o, i % 2 == 0); end
            step();
        end
        idle();
        #1;
        nchk++; if (outst_o !== 5'd4) begin nfail++; $display("FAIL rr_outst got=%0d exp=4", outst_o); end
        rob_rvalid_i = 1; r0_rready_i = 1; r1_rready_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            nchk++; if (r0_rvalid_o !== (i % 2 == 0) || r1_rvalid_o !== (i % 2 == 1)) begin nfail++; $display("FAIL rr_route[%0d] got=%b%b exp=%b%b", i, r1_rvalid_o, r0_rvalid_o, i % 2 == 1, i % 2 == 0); end
            step();
        end
        idle();
        #1;
        nchk++; if (outst_o !== 5'd0) begin nfail++; $display("FAIL rr_drain_outst got=%0d exp=0", outst_o); end
    endtask

    task automatic test_lock();
        r1_arid_i = 4'h5; r0_arid_i = 4'h3;
        r1_arvalid_i = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) r0_arvalid_i = 1;
            #1;
            nchk++; if (rob_arid_o !== 4'h5 || rob_arvalid_o !== 1'b1) begin nfail++; $display("FAIL lock_hold[%0d] got=%h/%b exp=5/1", i, rob_arid_o, rob_arvalid_o); end
            nchk++; if (r0_arready_o !== 1'b0) begin nfail++; $display("FAIL lock_r0_arready[%0d] got=%b exp=0", i, r0_arready_o); end
            step();
        end
        rob_arready_i = 1;
        #1;
        nchk++; if (r1_arready_o !== 1'b1 || rob_arid_o !== 4'h5) begin nfail++; $display("FAIL lock_hs got=%b/%h exp=1/5", r1_arready_o, rob_arid_o); end
        step();
        r1_arvalid_i = 0;
        #1;
        nchk++; if (rob_arid_o !== 4'h3 || r0_arready_o !== 1'b1) begin nfail++; $display("FAIL lock_next got=%h/%b exp=3/1", rob_arid_o, r0_arready_o); end
        step();
        idle();
        #1;
        nchk++; if (outst_o !== 5'd2) begin nfail++; $display("FAIL lock_outst got=%0d exp=2", outst_o); end
        rob_rvalid_i = 1; r0_rready_i = 1; r1_rready_i = 1;
        #1;
        nchk++; if (r1_rvalid_o !== 1'b1 || r0_rvalid_o !== 1'b0) begin nfail++; $display("FAIL lock_route0 got=%b%b exp=10", r1_rvalid_o, r0_rvalid_o); end
        step();
        nchk++; if (r0_rvalid_o !== 1'b1 || r1_rvalid_o !== 1'b0) begin nfail++; $display("FAIL lock_route1 got=%b%b exp=01", r1_rvalid_o, r0_rvalid_o); end
        step();
        idle();
    endtask

    task automatic test_full();
        r0_arid_i = 4'h9;
        r0_arvalid_i = 1; rob_arready_i = 1;
        for (int i = 0; i < 16; i++) step();
        nchk++; if (outst_o !== 5'd16) begin nfail++; $display("FAIL full_outst got=%0d exp=16", outst_o); end
        nchk++; if (rob_arvalid_o !== 1'b0 || r0_arready_o !== 1'b0) begin nfail++; $display("FAIL full_block got=%b/%b exp=0/0", rob_arvalid_o, r0_arready_o); end
        rob_rvalid_i = 1; r0_rready_i = 1;
        #1;
        nchk++; if (rob_rready_o !== 1'b1 || rob_arvalid_o !== 1'b0) begin nfail++; $display("FAIL full_same_cycle got=%b/%b exp=1/0", rob_rready_o, rob_arvalid_o); end
        step();
        rob_rvalid_i = 0;
        #1;
        nchk++; if (outst_o !== 5'd15 || rob_arvalid_o !== 1'b1) begin nfail++; $display("FAIL full_credit got=%0d/%b exp=15/1", outst_o, rob_arvalid_o); end
        step();
        nchk++; if (outst_o !== 5'd16) begin nfail++; $display("FAIL full_refill got=%0d exp=16", outst_o); end
        r0_arvalid_i = 0;
        rob_rvalid_i = 1;
        for (int i = 0; i < 16; i++) step();
        idle();
        #1;
        nchk++; if (outst_o !== 5'd0) begin nfail++; $display("FAIL full_drain got=%0d exp=0", outst_o); end
    endtask

    task automatic test_order();
        r0_arid_i = 4'h2; r1_arid_i = 4'h7;
        r0_arvalid_i = 1; rob_arready_i = 1;
        step();
        r0_arvalid_i = 0; r1_arvalid_i = 1;
        step(); step();
        idle();
        rob_rvalid_i = 1; rob_rid_i = 4'h2; rob_rdata_i = 8'hA0; r0_rready_i = 1;
        #1;
        nchk++; if (r0_rvalid_o !== 1'b1 || r0_rid_o !== 4'h2 || rob_rready_o !== 1'b1) begin nfail++; $display("FAIL order_beat0 got=%b/%h/%b exp=1/2/1", r0_rvalid_o, r0_rid_o, rob_rready_o); end
        step();
        rob_rid_i = 4'h7; rob_rdata_i = 8'hB1;
        #1;
        nchk++; if (r1_rvalid_o !== 1'b1 || r0_rvalid_o !== 1'b0 || rob_rready_o !== 1'b0) begin nfail++; $display("FAIL order_stall got=%b/%b/%b exp=1/0/0", r1_rvalid_o, r0_rvalid_o, rob_rready_o); end
        step();
        nchk++; if (outst_o !== 5'd2) begin nfail++; $display("FAIL order_stall_outst got=%0d exp=2", outst_o); end
        r1_rready_i = 1;
        #1;
        nchk++; if (rob_rready_o !== 1'b1 || r1_rid_o !== 4'h7 || r1_rdata_o !== 8'hB1) begin nfail++; $display("FAIL order_beat1 got=%b/%h/%h exp=1/7/b1", rob_rready_o, r1_rid_o, r1_rdata_o); end
        step();
        rob_rid_i = 4'h9; rob_rdata_i = 8'hC2;
        #1;
        nchk++; if (r1_rvalid_o !== 1'b1 || r1_rid_o !== 4'h9 || r1_rdata_o !== 8'hC2) begin nfail++; $display("FAIL order_beat2 got=%b/%h/%h exp=1/9/c2", r1_rvalid_o, r1_rid_o, r1_rdata_o); end
        step();
        idle();
        #1;
        nchk++; if (outst_o !== 5'd0) begin nfail++; $display("FAIL order_outst got=%0d exp=0", outst_o); end
    endtask

    task automatic test_error();
        r0_arvalid_i = 1; rob_arready_i = 1;
        step();
        idle();
        rst_n = 0;
        #2;
        rst_n = 1;
        step();
        nchk++; if (outst_o !== 5'd0) begin nfail++; $display("FAIL err_midreset_outst got=%0d exp=0", outst_o); end
        rob_rvalid_i = 1; r0_rready_i = 1; r1_rready_i = 1;
        #1;
        nchk++; if (rob_rready_o !== 1'b0 || r0_rvalid_o !== 1'b0 || r1_rvalid_o !== 1'b0) begin nfail++; $display("FAIL err_drop got=%b/%b/%b exp=0/0/0", rob_rready_o, r0_rvalid_o, r1_rvalid_o); end
        nchk++; if (err_o !== 1'b0) begin nfail++; $display("FAIL err_early got=%b exp=0", err_o); end
        step();
        idle();
        step();
        nchk++; if (err_o !== 1'b1) begin nfail++; $display("FAIL err_sticky got=%b exp=1", err_o); end
        rst_n = 0;
        #2;
        nchk++; if (err_o !== 1'b0 || outst_o !== 5'd0) begin nfail++; $display("FAIL err_clear got=%b/%0d exp=0/0", err_o, outst_o); end
        rst_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_order();
        test_error();
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
